// File: rtl/flattened_core.sv
// flattened_core: network-loaded 32-bit core running a 16-bit ISA with a valid/yumi data-memory port.
// Optional macro CORE_DEBUG_EN drives debug_flat_o with {PC, instruction}; otherwise it is tied to 0.
`timescale 1ns/1ps
module flattened_core #(
  parameter int unsigned imem_addr_width_p = 10,
  parameter logic [9:0]  net_ID_p          = 10'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [59:0] net_packet_flat_i,
  output logic [59:0] net_packet_flat_o,
  input  logic [33:0] from_mem_flat_i,
  output logic [35:0] to_mem_flat_o,
  output logic [31:0] data_mem_addr,
  output logic [2:0]  barrier_o,
  output logic        exception_o,
  output logic [31:0] debug_flat_o
);
  localparam int unsigned ImemDepth = 2 ** imem_addr_width_p;
  localparam int unsigned W = imem_addr_width_p;

  typedef enum logic [1:0] {IDLE, RUN, MEM, HALT} state_e;
  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_ADDU = 5'd1,  OP_SUBU = 5'd2,  OP_AND   = 5'd3,
    OP_OR   = 5'd4,  OP_XOR  = 5'd5,  OP_SLLV = 5'd6,  OP_SRLV  = 5'd7,
    OP_RORV = 5'd8,  OP_MOV  = 5'd9,  OP_ADDI = 5'd10, OP_MOVI  = 5'd11,
    OP_LW   = 5'd12, OP_SW   = 5'd13, OP_BEQZ = 5'd14, OP_BNEQZ = 5'd15,
    OP_JALR = 5'd16, OP_BAR  = 5'd17, OP_WAIT = 5'd18
  } op_e;

  state_e        state_q, state_d;
  logic [W-1:0]  pc_q, pc_d;
  logic [2:0]    barrier_q, barrier_d;
  logic [2:0]    mask_q, mask_d;
  logic          exception_q, exception_d;
  logic [15:0]   imem_q [ImemDepth];
  logic [31:0]   rf_q [32];

  // Network packet fields
  logic [9:0]  pkt_id, pkt_addr;
  logic [2:0]  pkt_op;
  logic [31:0] pkt_data;
  logic        pkt_hit, net_instr, net_reg, net_pc, net_bar;
  logic        unused_bits;

  assign pkt_id    = net_packet_flat_i[59:50];
  assign pkt_op    = net_packet_flat_i[49:47];
  assign pkt_data  = net_packet_flat_i[41:10];
  assign pkt_addr  = net_packet_flat_i[9:0];
  assign pkt_hit   = (pkt_id == net_ID_p);
  assign net_instr = pkt_hit && (pkt_op == 3'd1);
  assign net_reg   = pkt_hit && (pkt_op == 3'd2);
  assign net_pc    = pkt_hit && (pkt_op == 3'd3);
  assign net_bar   = pkt_hit && (pkt_op == 3'd4);
  assign unused_bits = ^{net_packet_flat_i[46:42], from_mem_flat_i[0]};

  // Instruction decode
  logic [15:0]  instr;
  op_e          op;
  logic [4:0]   rd_idx, rs_idx;
  logic [31:0]  rd_val, rs_val, imm;
  logic [W-1:0] pc_inc;

  assign instr  = imem_q[pc_q];
  assign op     = op_e'(instr[15:11]);
  assign rd_idx = instr[10:6];
  assign rs_idx = instr[4:0];
  assign imm    = {{26{instr[5]}}, instr[5:0]};
  assign rd_val = rf_q[rd_idx];
  assign rs_val = rf_q[rs_idx];
  assign pc_inc = pc_q + 1'b1;

  logic        mem_valid, mem_yumi, wb_en;
  logic [31:0] wb_data;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    barrier_d   = barrier_q;
    mask_d      = mask_q;
    exception_d = exception_q;
    wb_en       = 1'b0;
    wb_data     = '0;
    mem_valid   = 1'b0;
    mem_yumi    = 1'b0;
    case (state_q)
      RUN: begin
        pc_d = pc_inc;
        case (op)
          OP_NOP:   ;
          OP_ADDU:  begin wb_en = 1'b1; wb_data = rd_val + rs_val; end
          OP_SUBU:  begin wb_en = 1'b1; wb_data = rd_val - rs_val; end
          OP_AND:   begin wb_en = 1'b1; wb_data = rd_val & rs_val; end
          OP_OR:    begin wb_en = 1'b1; wb_data = rd_val | rs_val; end
          OP_XOR:   begin wb_en = 1'b1; wb_data = rd_val ^ rs_val; end
          OP_SLLV:  begin wb_en = 1'b1; wb_data = rd_val << rs_val[4:0]; end
          OP_SRLV:  begin wb_en = 1'b1; wb_data = rd_val >> rs_val[4:0]; end
          OP_RORV:  begin
            wb_en   = 1'b1;
            wb_data = (rd_val >> rs_val[4:0]) | (rd_val << (6'd32 - {1'b0, rs_val[4:0]}));
          end
          OP_MOV:   begin wb_en = 1'b1; wb_data = rs_val; end
          OP_ADDI:  begin wb_en = 1'b1; wb_data = rd_val + imm; end
          OP_MOVI:  begin wb_en = 1'b1; wb_data = imm; end
          OP_LW, OP_SW: begin pc_d = pc_q; state_d = MEM; end
          OP_BEQZ:  if (rd_val == '0) pc_d = pc_q + imm[W-1:0];
          OP_BNEQZ: if (rd_val != '0) pc_d = pc_q + imm[W-1:0];
          OP_JALR:  begin wb_en = 1'b1; wb_data = 32'(pc_inc); pc_d = rs_val[W-1:0]; end
          OP_BAR:   barrier_d = rs_val[2:0] & mask_q;
          OP_WAIT:  state_d = IDLE;
          default:  begin pc_d = pc_q; exception_d = 1'b1; state_d = HALT; end
        endcase
      end
      MEM: begin
        mem_valid = 1'b1;
        if (from_mem_flat_i[1]) begin
          mem_yumi = 1'b1;
          pc_d     = pc_inc;
          state_d  = RUN;
          if (op == OP_LW) begin
            wb_en   = 1'b1;
            wb_data = from_mem_flat_i[33:2];
          end
        end
      end
      default: ;
    endcase
    if (net_bar) mask_d = pkt_data[2:0];
    // A PC packet restarts the core and discards whatever the current cycle would have committed.
    if (net_pc) begin
      state_d     = RUN;
      pc_d        = pkt_addr[W-1:0];
      barrier_d   = pkt_data[2:0];
      exception_d = 1'b0;
      wb_en       = 1'b0;
      mem_yumi    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      barrier_q   <= '0;
      mask_q      <= '0;
      exception_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      barrier_q   <= barrier_d;
      mask_q      <= mask_d;
      exception_q <= exception_d;
    end
  end

  // Network register write is applied last so it wins over a same-cycle writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (net_instr) imem_q[pkt_addr[W-1:0]] <= pkt_data[15:0];
      if (wb_en)     rf_q[rd_idx] <= wb_data;
      if (net_reg)   rf_q[pkt_addr[4:0]] <= pkt_data;
    end
  end

  assign net_packet_flat_o = '0;
  assign to_mem_flat_o     = {(mem_valid ? rd_val : 32'd0), mem_valid,
                              mem_valid && (op == OP_SW), 1'b0, mem_yumi};
  assign data_mem_addr     = mem_valid ? rs_val : '0;
  assign barrier_o         = barrier_q;
  assign exception_o       = exception_q;

`ifdef CORE_DEBUG_EN
  assign debug_flat_o = {16'(pc_q), instr};
`else
  assign debug_flat_o = '0;
`endif

endmodule

// File: tb/tb_flattened_core.sv
// Scoreboard bench for flattened_core: an instruction-level reference model predicts memory traffic and barrier/exception state.
`timescale 1ns/1ps
module tb_flattened_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [59:0] net_pkt, net_out;
  logic [33:0] from_mem;
  logic [35:0] to_mem;
  logic [31:0] mem_addr, dbg;
  logic [2:0]  barrier;
  logic        exc;

  always #5 clk = ~clk;

  flattened_core #(.imem_addr_width_p(10), .net_ID_p(10'b1)) dut (
    .clk(clk), .reset(reset),
    .net_packet_flat_i(net_pkt), .net_packet_flat_o(net_out),
    .from_mem_flat_i(from_mem), .to_mem_flat_o(to_mem),
    .data_mem_addr(mem_addr), .barrier_o(barrier),
    .exception_o(exc), .debug_flat_o(dbg)
  );

  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'h9e3779b9 * i + 32'd7;
  endfunction

  // Single-cycle-response data memory attached to the core
  logic [31:0] mem_arr [256];
  assign from_mem = {mem_arr[mem_addr[9:2]], to_mem[3], to_mem[3]};
  always @(posedge clk) if (to_mem[3] && to_mem[2]) mem_arr[mem_addr[9:2]] <= to_mem[35:4];

  // Reference model state
  logic [15:0] m_imem [1024];
  bit   [31:0] m_rf   [32];
  bit   [31:0] m_mem  [256];
  bit   [2:0]  m_bar, m_mask;
  bit          m_exc;

  typedef struct { bit wen; bit [31:0] addr; bit [31:0] wdata; } acc_t;
  acc_t exp_q[$];
  acc_t e;
  int   cyc = 0;
  int   yumi_cyc[$];
  int   n_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle the core presents a request is checked against the head of the queue
  always @(negedge clk) begin
    if (!reset) begin
      if (to_mem[3]) begin
        n_valid++;
        yumi_cyc.push_back(cyc);
        check("yumi_on_response", to_mem[0], 1);
        check("byte_not_word", to_mem[1], 0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_access: got addr %h wen %b, expected no access", mem_addr, to_mem[2]);
        end else begin
          e = exp_q.pop_front();
          check("acc_wen", to_mem[2], e.wen);
          check("acc_addr", mem_addr, e.addr);
          if (e.wen) check("acc_wdata", to_mem[35:4], e.wdata);
        end
      end else begin
        check("idle_ctrl", {to_mem[2], to_mem[0]}, 0);
      end
    end
  end

  // Instruction-level model: executes from start until WAIT/exception, queueing expected accesses
  task automatic model_run(input int start, output int cycles);
    int pc, nxt, op, rd, rsi, imm, sh;
    bit [31:0] a, b;
    bit done;
    acc_t t;
    pc = start; cycles = 0; done = 0;
    for (int step = 0; step < 4000 && !done; step++) begin
      op  = m_imem[pc][15:11];
      rd  = m_imem[pc][10:6];
      rsi = m_imem[pc][5:0];
      imm = (rsi >= 32) ? rsi - 64 : rsi;
      a   = m_rf[rd];
      b   = m_rf[rsi % 32];
      sh  = b % 32;
      nxt = (pc + 1) % 1024;
      cycles++;
      case (op)
        0:  ;
        1:  m_rf[rd] = a + b;
        2:  m_rf[rd] = a - b;
        3:  m_rf[rd] = a & b;
        4:  m_rf[rd] = a | b;
        5:  m_rf[rd] = a ^ b;
        6:  m_rf[rd] = a << sh;
        7:  m_rf[rd] = a >> sh;
        8:  m_rf[rd] = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
        9:  m_rf[rd] = b;
        10: m_rf[rd] = a + imm;
        11: m_rf[rd] = imm;
        12: begin
          t.wen = 0; t.addr = b; t.wdata = a; exp_q.push_back(t);
          m_rf[rd] = m_mem[b[9:2]];
          cycles++;
        end
        13: begin
          t.wen = 1; t.addr = b; t.wdata = a; exp_q.push_back(t);
          m_mem[b[9:2]] = a;
          cycles++;
        end
        14: if (a == 0) nxt = ((pc + imm) % 1024 + 1024) % 1024;
        15: if (a != 0) nxt = ((pc + imm) % 1024 + 1024) % 1024;
        16: begin m_rf[rd] = nxt; nxt = b % 1024; end
        17: m_bar = b[2:0] & m_mask;
        18: done = 1;
        default: begin m_exc = 1; done = 1; nxt = pc; end
      endcase
      pc = nxt;
    end
  endtask

  function automatic logic [59:0] pkt(input logic [2:0] op, input logic [31:0] data, input logic [9:0] addr);
    return {10'd1, op, 5'd0, data, addr};
  endfunction

  function automatic logic [15:0] ins(input int op, input int rd, input int rsi);
    return {op[4:0], rd[4:0], rsi[5:0]};
  endfunction

  task automatic send(input logic [59:0] p);
    @(negedge clk);
    net_pkt = p;
    @(negedge clk);
    net_pkt = '0;
  endtask

  task automatic load_prog(input int base, input logic [15:0] prog[$]);
    foreach (prog[i]) begin
      send(pkt(3'd1, {16'd0, prog[i]}, 10'(base + i)));
      m_imem[base + i] = prog[i];
    end
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    send(pkt(3'd2, v, 10'(r)));
    m_rf[r] = v;
  endtask

  task automatic set_mask(input logic [2:0] m);
    send(pkt(3'd4, {29'd0, m}, 10'd0));
    m_mask = m;
  endtask

  task automatic run(input int base, input logic [2:0] bar);
    int n;
    m_bar = bar;
    m_exc = 0;
    model_run(base, n);
    send(pkt(3'd3, {29'd0, bar}, 10'(base)));
    check("barrier_after_pc", barrier, bar);
    check("exception_after_pc", exc, 0);
    repeat (n + 3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("barrier_final", barrier, m_bar);
    check("exception_final", exc, m_exc);
  endtask

  logic [15:0] prog[$];
  int y0, v0, base_addr;
  logic [2:0] rbar;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = init_word(i);
      m_mem[i]   = init_word(i);
    end
    m_mask  = '0;
    reset   = 1'b1;
    net_pkt = '0;
    repeat (2) @(negedge clk);
    check("reset_barrier", barrier, 0);
    check("reset_exception", exc, 0);
    check("reset_to_mem", to_mem, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("net_out_null", net_out, 0);
`ifndef CORE_DEBUG_EN
    check("debug_tied_off", dbg, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Countdown loop, then store R2 to prove it reached zero
    prog = '{ins(11,2,5), ins(10,2,63), ins(15,2,63), ins(11,7,8), ins(13,2,7), ins(18,0,0)};
    load_prog(0, prog);
    run(0, 3'b010);
    check("loop_r2_zero", mem_arr[2], 0);
    v0 = n_valid;
    repeat (6) @(negedge clk);
    check("idle_after_wait", n_valid, v0);

    // Rotate, XOR, store/load round trip
    set_reg(1, 32'h56f6950a);
    set_reg(3, 32'd4);
    set_reg(10, 32'ha24c2683);
    set_reg(11, 32'hcf1beb52);
    prog = '{ins(8,1,3), ins(5,10,11), ins(11,7,16), ins(13,1,7), ins(12,5,7),
             ins(11,6,20), ins(13,5,6), ins(11,6,24), ins(13,10,6), ins(18,0,0)};
    load_prog(32, prog);
    y0 = yumi_cyc.size();
    v0 = n_valid;
    run(32, 3'b000);
    check("rorv_result", mem_arr[4], 32'ha56f6950);
    check("lw_roundtrip", mem_arr[5], 32'ha56f6950);
    check("xor_result", mem_arr[6], 32'h6d57cdd1);
    check("valid_cycles", n_valid - v0, 4);
    if (yumi_cyc.size() >= y0 + 2) check("lw_two_cycles", yumi_cyc[y0 + 1] - yumi_cyc[y0], 2);
    else check("yumi_seen", yumi_cyc.size() - y0, 4);

    // Barrier masking
    prog = '{ins(11,9,1), ins(17,0,9), ins(18,0,0)};
    load_prog(48, prog);
    set_mask(3'b111);
    run(48, 3'b110);
    check("bar_mask7", barrier, 3'b001);
    set_mask(3'b000);
    run(48, 3'b101);
    check("bar_mask0", barrier, 3'b000);

    // Ignored packets, then exception with frozen PC, then recovery
    set_reg(12, 32'h12345678);
    send({10'd2, 3'd2, 5'd0, 32'hdeadbeef, 10'd12});
    send(pkt(3'd5, 32'hbeefcafe, 10'd12));
    prog = '{ins(31,0,0), ins(13,1,7), ins(18,0,0)};
    load_prog(64, prog);
    run(64, 3'b000);
    check("exception_set", exc, 1);
    repeat (4) @(negedge clk);
    check("exception_sticky", exc, 1);
    prog = '{ins(11,7,28), ins(13,12,7), ins(18,0,0)};
    load_prog(72, prog);
    run(72, 3'b011);
    check("ignored_packets", mem_arr[7], 32'h12345678);

    // Randomized ALU programs checked through stores
    for (int it = 0; it < 4; it++) begin
      for (int r = 8; r < 16; r++) set_reg(r, $urandom);
      base_addr = 256 + it * 64;
      set_reg(16, 32'(base_addr));
      set_mask(3'($urandom_range(0, 7)));
      prog.delete();
      for (int k = 0; k < 16; k++) begin
        int op, rd, rsi;
        op  = $urandom_range(1, 11);
        rd  = $urandom_range(8, 15);
        rsi = (op >= 10) ? $urandom_range(0, 63) : $urandom_range(8, 15);
        prog.push_back(ins(op, rd, rsi));
      end
      prog.push_back(ins(17, 0, $urandom_range(8, 15)));
      for (int r = 8; r < 16; r++) begin
        prog.push_back(ins(13, r, 16));
        prog.push_back(ins(10, 16, 4));
      end
      prog.push_back(ins(10, 16, 60));
      prog.push_back(ins(12, 17, 16));
      prog.push_back(ins(10, 16, 8));
      prog.push_back(ins(13, 17, 16));
      prog.push_back(ins(18, 0, 0));
      load_prog(128, prog);
      rbar = 3'($urandom_range(0, 7));
      run(128, rbar);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
